// File: rtl/stim_multi_ch_pkg.sv
// Shared definitions for the multi-channel stimulus/check block.
// Holds the mode encodings, FSM states and PRBS7 constants.
package stim_multi_ch_pkg;

    localparam int unsigned MODE_W = 3;
    localparam int unsigned PRBS_W = 7;

    localparam logic [MODE_W-1:0] MODE_OFF  = 3'd0;
    localparam logic [MODE_W-1:0] MODE_C0   = 3'd1;
    localparam logic [MODE_W-1:0] MODE_C1   = 3'd2;
    localparam logic [MODE_W-1:0] MODE_SEQ  = 3'd3;
    localparam logic [MODE_W-1:0] MODE_PRBS = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // x^7 + x^6 + 1: feedback from bits 6 and 5
    localparam logic [PRBS_W-1:0] PRBS_TAPS      = 7'h60;
    localparam logic [PRBS_W-1:0] PRBS_SEED_BASE = 7'h7F;

    function automatic logic [PRBS_W-1:0] prbs_seed(input int unsigned ch);
        return PRBS_SEED_BASE ^ PRBS_W'(ch);
    endfunction

    function automatic logic [PRBS_W-1:0] prbs_next(input logic [PRBS_W-1:0] s);
        return {s[PRBS_W-2:0], ^(s & PRBS_TAPS)};
    endfunction

    function automatic logic is_chk_mode(input logic [MODE_W-1:0] m);
        return (m == MODE_SEQ) || (m == MODE_PRBS);
    endfunction

endpackage

// File: rtl/stim_chk_ch.sv
// One channel: PRBS7 generator, delayed expected-value tap and
// saturating mismatch counter.
module stim_chk_ch
    import stim_multi_ch_pkg::*;
#(
    parameter int unsigned CH    = 0,
    parameter int unsigned CNT_W = 32,
    parameter int unsigned LAT   = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             dout_i,
    input  logic             din_i,
    input  logic             chk_en_i,
    output logic             prbs_msb_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    logic [PRBS_W-1:0] prbs_q;
    logic [LAT-1:0]    dly_q;
    logic [CNT_W-1:0]  err_q;
    logic              exp_c;

    assign exp_c      = dly_q[LAT-1];
    assign prbs_msb_o = prbs_q[PRBS_W-1];
    assign err_cnt_o  = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prbs_q <= prbs_seed(CH);
            err_q  <= '0;
        end else begin
            if (load_i) begin
                prbs_q <= prbs_seed(CH);
            end else if (shift_i) begin
                prbs_q <= prbs_next(prbs_q);
            end
            if (clr_i) begin
                err_q <= '0;
            end else if (chk_en_i && (din_i != exp_c) && (err_q != '1)) begin
                err_q <= err_q + CNT_W'(1);
            end
        end
    end

    // Expected value: the driven bit as it looked LAT cycles ago
    if (LAT > 1) begin : g_dly_n
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                dly_q <= '0;
            end else begin
                dly_q <= {dly_q[LAT-2:0], dout_i};
            end
        end
    end else begin : g_dly_1
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                dly_q <= '0;
            end else begin
                dly_q <= dout_i;
            end
        end
    end

endmodule

// File: rtl/stim_multi_ch.sv
// Multi-channel pattern driver with loopback checker: drives constant,
// table or PRBS7 patterns and counts mismatches on the returned data.
module stim_multi_ch
    import stim_multi_ch_pkg::*;
#(
    parameter  int unsigned N_CH    = 4,
    parameter  int unsigned SEQ_LEN = 8,
    parameter  int unsigned CNT_W   = 32,
    parameter  int unsigned LAT     = 2,
    localparam int unsigned AW      = $clog2(SEQ_LEN)
) (
    input  logic                  CLK,
    input  logic                  RSTX,
    input  logic                  CLR,
    input  logic [2:0]            MODE,
    input  logic                  START,
    input  logic                  STOP,
    input  logic                  PTN_WE,
    input  logic [AW-1:0]         PTN_ADDR,
    input  logic [N_CH-1:0]       PTN_WDATA,
    input  logic [N_CH-1:0]       DIN,
    output logic [N_CH-1:0]       DOUT,
    output logic [N_CH-1:0]       DOE,
    output logic                  BUSY,
    output logic [CNT_W-1:0]      RECV_CNT,
    output logic [N_CH*CNT_W-1:0] ERR_CNT
);

    localparam int unsigned RC_W = 5;

    state_e              state_q, state_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [RC_W-1:0]     run_cnt_q, run_cnt_d;
    logic [N_CH-1:0]     dout_q, dout_d;
    logic [N_CH-1:0]     doe_q, doe_d;
    logic                busy_q;
    logic [CNT_W-1:0]    recv_q, recv_d;
    logic [N_CH-1:0]     tbl_q [SEQ_LEN];
    logic [N_CH-1:0]     prbs_msb;
    logic                chk_en_c;
    logic                prbs_load_c;
    logic                prbs_shift_c;
    logic                chk_window_c;

    assign DOUT     = dout_q;
    assign DOE      = doe_q;
    assign BUSY     = busy_q;
    assign RECV_CNT = recv_q;

    // Checker opens once LAT RUN cycles have filled the delay line
    assign chk_window_c = run_cnt_q >= RC_W'(LAT);

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_OFF;
            addr_q    <= '0;
            run_cnt_q <= '0;
            dout_q    <= '0;
            doe_q     <= '0;
            busy_q    <= 1'b0;
            recv_q    <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            addr_q    <= addr_d;
            run_cnt_q <= run_cnt_d;
            dout_q    <= dout_d;
            doe_q     <= doe_d;
            busy_q    <= (state_d != ST_IDLE);
            recv_q    <= recv_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        addr_d       = addr_q;
        run_cnt_d    = run_cnt_q;
        dout_d       = '0;
        doe_d        = '0;
        recv_d       = recv_q;
        chk_en_c     = 1'b0;
        prbs_load_c  = 1'b0;
        prbs_shift_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START && !STOP) begin
                    state_d = ST_ARM;
                    mode_d  = MODE;
                end
            end
            ST_ARM: begin
                state_d     = ST_RUN;
                addr_d      = '0;
                run_cnt_d   = '0;
                prbs_load_c = 1'b1;
            end
            ST_RUN: begin
                addr_d       = addr_q + AW'(1);
                prbs_shift_c = 1'b1;
                if (!chk_window_c) begin
                    run_cnt_d = run_cnt_q + RC_W'(1);
                end
                case (mode_q)
                    MODE_C0:   doe_d = '1;
                    MODE_C1: begin
                        doe_d  = '1;
                        dout_d = '1;
                    end
                    MODE_SEQ: begin
                        doe_d  = '1;
                        dout_d = tbl_q[addr_q];
                    end
                    MODE_PRBS: begin
                        doe_d  = '1;
                        dout_d = prbs_msb;
                    end
                    default: ;
                endcase
                chk_en_c = chk_window_c && is_chk_mode(mode_q);
                if (chk_en_c && (recv_q != '1)) begin
                    recv_d = recv_q + CNT_W'(1);
                end
                if (STOP) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (CLR) begin
            state_d  = ST_IDLE;
            recv_d   = '0;
            dout_d   = '0;
            doe_d    = '0;
            chk_en_c = 1'b0;
        end
    end

    // Pattern table is deliberately outside reset so contents survive it
    always_ff @(posedge CLK) begin
        if (PTN_WE && (state_q == ST_IDLE)) begin
            tbl_q[PTN_ADDR] <= PTN_WDATA;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        stim_chk_ch #(
            .CH    (k),
            .CNT_W (CNT_W),
            .LAT   (LAT)
        ) u_ch (
            .clk_i      (CLK),
            .rst_ni     (RSTX),
            .clr_i      (CLR),
            .load_i     (prbs_load_c),
            .shift_i    (prbs_shift_c),
            .dout_i     (dout_q[k]),
            .din_i      (DIN[k]),
            .chk_en_i   (chk_en_c),
            .prbs_msb_o (prbs_msb[k]),
            .err_cnt_o  (ERR_CNT[k*CNT_W +: CNT_W])
        );
    end

endmodule

// File: doc/stim_multi_ch.md
STIM_MULTI_CH -- requirements
Module: stim_multi_ch

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of stimulus/check channels, range 1..64.
REQ-002 SHALL have parameter SEQ_LEN, default 8: pattern table depth, a power of two from 2 to 256; AW = log2(SEQ_LEN).
REQ-003 SHALL have parameter CNT_W, default 32: width of the receive and error counters.
REQ-004 SHALL have parameter LAT, default 2: loop latency from DOUT to DIN in cycles, range 1..15.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 Ports, clock and reset first:
- CLK  in  1  clock.
- RSTX  in  1  asynchronous active-low reset.
- CLR  in  1  synchronous clear.
- MODE  in  3  run mode.
- START  in  1  start pulse.
- STOP  in  1  stop pulse.
- PTN_WE  in  1  pattern write strobe.
- PTN_ADDR  in  AW  pattern write address.
- PTN_WDATA  in  N_CH  pattern word.
- DIN  in  N_CH  returned data.
- DOUT  out  N_CH  drive value.
- DOE  out  N_CH  drive enable; 0 means high-Z at the pad.
- BUSY  out  1  FSM not in IDLE.
- RECV_CNT  out  CNT_W  compared-cycle count.
- ERR_CNT  out  N_CH*CNT_W  per-channel mismatch counts; channel k occupies bits [k*CNT_W +: CNT_W].

Function
REQ-007 SHALL implement an FSM with states IDLE, ARM and RUN.
- IDLE -> ARM on START.
- ARM -> RUN after exactly 1 cycle.
- RUN -> IDLE on STOP or CLR.
REQ-008 SHALL latch MODE into the active mode only on an IDLE cycle with START=1; MODE changes during ARM or RUN are ignored.
REQ-009 SHALL ignore START while ARM or RUN.
REQ-010 SHALL give STOP priority over START when both are asserted in the same cycle.
REQ-011 In ARM, SHALL reset the pattern address to 0 and load each channel k PRBS7 register with 7'h7F ^ k.
REQ-012 In RUN, SHALL drive outputs registered by the active mode (1-cycle latency):
- 0: DOE=0.
- 1: DOE=all 1, DOUT=0.
- 2: DOE=all 1, DOUT=all 1.
- 3 (SEQ): DOE=all 1, DOUT=table[addr].
- 4 (PRBS): DOE=all 1, DOUT[k]=PRBS7 MSB of channel k.
- 5..7: behave as mode 0.
REQ-013 In SEQ mode, the address SHALL increment every RUN cycle and wrap from SEQ_LEN-1 to 0.
REQ-014 The PRBS polynomial SHALL be x^7+x^6+1, shifted every RUN cycle, giving period 127.
REQ-015 The pattern table SHALL be written on PTN_WE only when BUSY=0; writes while BUSY=1 are dropped. Table contents are not affected by reset.
REQ-016 The checker SHALL be active in modes 3 and 4 from the (LAT+1)th RUN cycle onward. The expected value is DOUT delayed by LAT cycles through an internal shift register.
REQ-017 On each active check cycle, SHALL increment RECV_CNT by 1, and increment ERR_CNT[k] by 1 when DIN[k] differs from expected[k].
REQ-018 All counters SHALL saturate at all-ones and never wrap.
REQ-019 Counters SHALL hold their values in IDLE and on leaving RUN. They clear only on CLR or reset.
REQ-020 CLR SHALL, in one cycle:
- zero all counters;
- force IDLE;
- set DOE=0.
The table is not affected. CLR wins over START and STOP.
REQ-021 In IDLE and ARM, SHALL drive DOE=0 and DOUT=0.
REQ-022 BUSY SHALL be 1 in ARM and RUN and 0 otherwise.

Reset
REQ-023 On RSTX low, asynchronously and regardless of CLK:
- FSM=IDLE, active mode=0.
- DOUT=0, DOE=0, BUSY=0.
- RECV_CNT=0, all ERR_CNT=0.
- Delay line=0, address=0.
REQ-024 Reset asserted mid-RUN SHALL take effect with no further counter increments.

Structure
REQ-025 A shared package SHALL hold:
- the mode encodings (MODE_OFF, MODE_C0, MODE_C1, MODE_SEQ, MODE_PRBS);
- the FSM state enum;
- the PRBS7 taps and seed base.
REQ-026 SHALL contain one sub-module, stim_chk_ch: per-channel PRBS7 generator, expected-delay tap compare, and saturating error counter, instantiated N_CH times.

Verification
REQ-027 Mode 2, START, RUN 10 cycles, DIN tied high -> DOE=1111 and DOUT=1111 from the 2nd RUN cycle; RECV_CNT=0 and ERR_CNT=0, since no check in mode 2.
REQ-028 Table loaded with 0..7, mode 3, DIN=DOUT delayed 2 cycles, run 20 cycles then STOP -> DOUT sequence 0,1,..,7,0 wraps; RECV_CNT=18 and all ERR_CNT=0.
REQ-029 Mode 4, loopback delayed 2 cycles with DIN[1] inverted, run 200 cycles -> ERR_CNT[1]=RECV_CNT=198 and other channels 0; channel 0 DOUT repeats with period 127.
REQ-030 CNT_W=4, mode 4, all DIN inverted, run 40 cycles -> every ERR_CNT=15 and RECV_CNT=15, both saturated without wrap.
REQ-031 PTN_WE during RUN writes 0xF to address 0 -> table unchanged on the next pass. CLR mid-RUN -> BUSY=0, DOE=0 and all counters 0 on the next cycle.
REQ-032 RSTX pulsed low mid-RUN between clock edges -> all outputs 0 immediately. START and STOP asserted in the same IDLE cycle -> remains IDLE.
